// File: rtl/booth_appr_mul_seq_if.sv
// Operand/result handshake bundle for booth_appr_mul_seq.
// Master drives operands and out_ready; slave (the multiplier) drives in_ready and the result.
// Ports: in_valid/in_ready/in_a/in_b (operand side), out_valid/out_ready/out_data (result side).
interface booth_appr_mul_seq_if #(
    parameter int W = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic signed [W-1:0]   in_a;
    logic signed [W-1:0]   in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [2*W-1:0] out_data;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/booth_appr_mul_seq.sv
// Iterative radix-4 Booth signed fixed-point multiplier with per-term low-column truncation.
// Latency: accept edge to out_valid = W/2+1 cycles; one operation in flight at a time.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, rst (async, active-high), mul_if (slave modport of booth_appr_mul_seq_if).
// Optional macro APPR_COMP_EN: preload the accumulator with a bias offsetting mean truncation error.
module booth_appr_mul_seq #(
    parameter int W          = 16,
    parameter int SHIFT      = 8,
    parameter int TRUNC_COLS = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_appr_mul_seq_if.slave  mul_if
);
    localparam int P        = 2 * W;
    localparam int NDIG     = W / 2;
    localparam int CW       = $clog2(NDIG + 1);
    localparam int N_TR_RAW = (TRUNC_COLS + 1) / 2;
    localparam int N_TR     = (N_TR_RAW < NDIG) ? N_TR_RAW : NDIG;
    localparam int BIAS_SH  = (TRUNC_COLS > 0) ? TRUNC_COLS - 1 : 0;

    // Columns below TRUNC_COLS are cleared in every Booth term; shifting by P yields all-zero.
    localparam logic [P-1:0] KEEP_MASK = {P{1'b1}} << TRUNC_COLS;

`ifdef APPR_COMP_EN
    localparam logic [P-1:0] ACC_INIT = (TRUNC_COLS > 0) ? (P'(N_TR) << BIAS_SH) : '0;
`else
    localparam logic [P-1:0] ACC_INIT = '0;
`endif

    if (W < 4 || (W % 2) != 0) begin : g_bad_w
        $error("booth_appr_mul_seq: W must be even and >= 4");
    end
    if (TRUNC_COLS < 0 || TRUNC_COLS > P) begin : g_bad_trunc
        $error("booth_appr_mul_seq: TRUNC_COLS must be in 0..2W");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t         state_q;
    logic [P-1:0]   a_q;        // multiplicand, sign-extended, pre-shifted by 2i for the current digit
    logic [W-1:0]   b_q;        // multiplier, shifted right two bits per digit
    logic           bm1_q;      // b[2i-1] for the current digit
    logic [CW-1:0]  cnt_q;
    logic [P-1:0]   acc_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [P-1:0]   out_data_q;

    logic [P-1:0]   mag;
    logic           neg;
    logic [P-1:0]   term_d;
    logic [P-1:0]   acc_d;
    logic [P-1:0]   res_d;

    // Booth digit select from {b[2i+1], b[2i], b[2i-1]}; a_q already carries the << 2i.
    always_comb begin
        mag = '0;
        neg = 1'b0;
        case ({b_q[1], b_q[0], bm1_q})
            3'b001, 3'b010: mag = a_q;
            3'b011:         mag = a_q << 1;
            3'b100: begin   mag = a_q << 1; neg = 1'b1; end
            3'b101, 3'b110: begin mag = a_q; neg = 1'b1; end
            default:        mag = '0;
        endcase
        term_d = neg ? (~mag + P'(1)) : mag;
        acc_d  = acc_q + (term_d & KEEP_MASK);
        res_d  = P'($signed(acc_q) >>> SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            bm1_q       <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mul_if.in_valid && in_ready_q) begin
                        a_q        <= {{W{mul_if.in_a[W-1]}}, mul_if.in_a};
                        b_q        <= mul_if.in_b;
                        bm1_q      <= 1'b0;
                        cnt_q      <= '0;
                        acc_q      <= ACC_INIT;
                        in_ready_q <= 1'b0;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Digits are consumed while cnt < NDIG; the extra cycle at cnt == NDIG
                    // registers the shifted result.
                    if (cnt_q == CW'(NDIG)) begin
                        out_data_q  <= res_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        acc_q <= acc_d;
                        a_q   <= a_q << 2;
                        b_q   <= {2'b00, b_q[W-1:2]};
                        bm1_q <= b_q[1];
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (mul_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mul_if.in_ready  = in_ready_q;
    assign mul_if.out_valid = out_valid_q;
    assign mul_if.out_data  = out_data_q;
endmodule

// File: tb/tb_booth_appr_mul_seq.sv
// Bench for booth_appr_mul_seq: exact (SHIFT=8), truncated (SHIFT=0, T=4) and plain (SHIFT=0) instances.
// Directed vectors with hand-computed results, backpressure, reset abort, seeded random.
// Honours APPR_COMP_EN for the truncated instance's expected values.
module tb_booth_appr_mul_seq;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    booth_appr_mul_seq_if #(.W(16)) if0 ();
    booth_appr_mul_seq_if #(.W(16)) if1 ();
    booth_appr_mul_seq_if #(.W(16)) if2 ();

    booth_appr_mul_seq #(.W(16), .SHIFT(8), .TRUNC_COLS(0)) dut0 (.clk(clk), .rst(rst), .mul_if(if0));
    booth_appr_mul_seq #(.W(16), .SHIFT(0), .TRUNC_COLS(4)) dut1 (.clk(clk), .rst(rst), .mul_if(if1));
    booth_appr_mul_seq #(.W(16), .SHIFT(0), .TRUNC_COLS(0)) dut2 (.clk(clk), .rst(rst), .mul_if(if2));

`ifdef APPR_COMP_EN
    localparam int BIAS1 = 16;   // N_TR=2, 2<<3
`else
    localparam int BIAS1 = 0;
`endif

    task automatic drv(input int s, input logic v, input logic signed [15:0] a,
                       input logic signed [15:0] b, input logic r);
        case (s)
            0: begin if0.in_valid = v; if0.in_a = a; if0.in_b = b; if0.out_ready = r; end
            1: begin if1.in_valid = v; if1.in_a = a; if1.in_b = b; if1.out_ready = r; end
            default: begin if2.in_valid = v; if2.in_a = a; if2.in_b = b; if2.out_ready = r; end
        endcase
    endtask

    task automatic smp(input int s, output logic ir, output logic ov, output logic signed [31:0] od);
        case (s)
            0: begin ir = if0.in_ready; ov = if0.out_valid; od = if0.out_data; end
            1: begin ir = if1.in_ready; ov = if1.out_valid; od = if1.out_data; end
            default: begin ir = if2.in_ready; ov = if2.out_valid; od = if2.out_data; end
        endcase
    endtask

    // One operation with out_ready high; lat = cycles from accept edge to out_valid, -1 on timeout.
    task automatic run_op(input int s, input logic signed [15:0] a, input logic signed [15:0] b,
                          output logic signed [31:0] r, output int lat);
        logic ir, ov;
        logic signed [31:0] od;
        @(negedge clk);
        drv(s, 1'b1, a, b, 1'b1);
        @(posedge clk); #1;
        drv(s, 1'b0, 16'sd0, 16'sd0, 1'b1);
        lat = -1;
        od  = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            smp(s, ir, ov, od);
            if (ov) begin
                lat = k;
                break;
            end
        end
        r = od;
        @(posedge clk); #1;
    endtask

    function automatic logic signed [31:0] booth_trunc(input logic signed [15:0] a,
                                                       input logic signed [15:0] b, input int t);
        logic signed [31:0] acc, term, as;
        logic [16:0] bx;
        int d;
        acc = 0;
        as  = a;
        bx  = {b, 1'b0};
        for (int i = 0; i < 8; i++) begin
            d    = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
            term = d * as;
            term = term <<< (2 * i);
            term = term & ({32{1'b1}} << t);
            acc  = acc + term;
        end
        return acc;
    endfunction

    task automatic test_reset();
        logic ir, ov;
        logic signed [31:0] od;
        for (int s = 0; s < 3; s++) drv(s, 1'b0, 16'sd0, 16'sd0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            smp(s, ir, ov, od);
            total++;
            if ({ir, ov, od} !== {1'b1, 1'b0, 32'd0}) begin
                bad++;
                $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b out_data=%0d, want 1 0 0", s, ir, ov, od);
            end
        end
    endtask

    task automatic test_exact();
        logic signed [15:0] va [6] = '{16'sd100, -16'sd32768, 16'sd32767, -16'sd1, 16'sd0, 16'sd256};
        logic signed [15:0] vb [6] = '{-16'sd494, -16'sd32768, -16'sd32768, 16'sd1, 16'sd12345, 16'sd256};
        logic signed [31:0] ve [6] = '{-32'sd193, 32'sd4194304, -32'sd4194176, -32'sd1, 32'sd0, 32'sd256};
        logic signed [31:0] r;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(0, va[i], vb[i], r, lat);
            total++;
            if (r !== ve[i]) begin
                bad++;
                $display("FAIL exact_%0d: a=%0d b=%0d got %0d want %0d", i, va[i], vb[i], r, ve[i]);
            end
            total++;
            if (lat !== 9) begin
                bad++;
                $display("FAIL latency_%0d: got %0d cycles want 9", i, lat);
            end
        end
    endtask

    task automatic test_trunc();
        logic signed [15:0] va [4] = '{16'sd1, 16'sd3, 16'sd16, -16'sd1};
        logic signed [15:0] vb [4] = '{16'sd1, 16'sd2, 16'sd1, -16'sd1};
        int                 ve [4] = '{0, -16, 16, 0};
        logic signed [31:0] r;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(1, va[i], vb[i], r, lat);
            total++;
            if (r !== 32'(ve[i] + BIAS1)) begin
                bad++;
                $display("FAIL trunc_%0d: a=%0d b=%0d got %0d want %0d", i, va[i], vb[i], r, ve[i] + BIAS1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic ir, ov;
        logic signed [31:0] od;
        int k;
        @(negedge clk);
        drv(0, 1'b1, 16'sd100, -16'sd494, 1'b0);
        @(posedge clk); #1;
        drv(0, 1'b0, 16'sd7, 16'sd7, 1'b0);
        ov = 1'b0;
        k  = 0;
        while (!ov && k < 20) begin
            @(posedge clk); #1;
            smp(0, ir, ov, od);
            k++;
        end
        total++;
        if (!ov) begin
            bad++;
            $display("FAIL bp_wait: out_valid never rose within 20 cycles");
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            smp(0, ir, ov, od);
            total++;
            if ({ir, ov, od} !== {1'b0, 1'b1, -32'sd193}) begin
                bad++;
                $display("FAIL bp_hold_%0d: in_ready=%b out_valid=%b out_data=%0d, want 0 1 -193", c, ir, ov, od);
            end
        end
        @(negedge clk);
        drv(0, 1'b0, 16'sd0, 16'sd0, 1'b1);
        @(posedge clk); #1;
        smp(0, ir, ov, od);
        total++;
        if ({ir, ov} !== 2'b10) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", ir, ov);
        end
    endtask

    task automatic test_reset_abort();
        logic ir, ov;
        logic signed [31:0] od, r;
        int lat;
        @(negedge clk);
        drv(2, 1'b1, 16'sd9, 16'sd9, 1'b1);
        @(posedge clk); #1;                // accept edge: first BUSY cycle begins
        drv(2, 1'b0, 16'sd0, 16'sd0, 1'b1);
        repeat (2) @(posedge clk);         // now in the third BUSY cycle
        #2;
        rst = 1'b1;
        #1;
        smp(2, ir, ov, od);
        total++;
        if ({ir, ov} !== 2'b10) begin
            bad++;
            $display("FAIL abort_state: in_ready=%b out_valid=%b, want 1 0", ir, ov);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(2, 16'sd3, 16'sd7, r, lat);
        total++;
        if (r !== 32'sd21) begin
            bad++;
            $display("FAIL abort_next: got %0d want 21", r);
        end
    endtask

    task automatic test_random();
        logic signed [15:0] a, b;
        logic signed [31:0] r, exp_v;
        longint p;
        int lat;
        real err, sum, sumsq, mean, sd;
        int unsigned seed;
        seed = 200;
        void'($urandom(seed));
        for (int i = 0; i < 800; i++) begin
            a = 16'($urandom());
            b = 16'($urandom());
            p = longint'(a) * longint'(b);
            exp_v = 32'(p >>> 8);
            run_op(0, a, b, r, lat);
            total++;
            if (r !== exp_v) begin
                bad++;
                $display("FAIL rand_exact_%0d: a=%0d b=%0d got %0d want %0d", i, a, b, r, exp_v);
            end
        end
        sum = 0.0;
        sumsq = 0.0;
        for (int i = 0; i < 800; i++) begin
            a = 16'($urandom());
            b = 16'($urandom());
            exp_v = booth_trunc(a, b, 4) + 32'(BIAS1);
            run_op(1, a, b, r, lat);
            total++;
            if (r !== exp_v) begin
                bad++;
                $display("FAIL rand_trunc_%0d: a=%0d b=%0d got %0d want %0d", i, a, b, r, exp_v);
            end
            err   = real'(r) - real'(longint'(a) * longint'(b));
            sum   = sum + err;
            sumsq = sumsq + err * err;
        end
        mean = sum / 800.0;
        sd   = $sqrt(sumsq / 800.0 - mean * mean);
        $display("truncation error vs exact product (T=4): mean=%f std=%f", mean, sd);
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_exact();
        test_trunc();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
